// File: rtl/uart_rx_if.sv
// Bus-side view of the UART0 receiver: FIFO pop/clear controls and status.
// master = register block, slave = receiver.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             rd_en;
  logic             clr_err;
  logic [7:0]       rx_data;
  logic             rx_empty;
  logic             rx_full;
  logic [CNT_W-1:0] rx_count;
  logic             overrun;
  logic             frame_err;
  logic             irq;

  modport master (
    output rd_en, clr_err,
    input  rx_data, rx_empty, rx_full, rx_count, overrun, frame_err, irq
  );

  modport slave (
    input  rd_en, clr_err,
    output rx_data, rx_empty, rx_full, rx_count, overrun, frame_err, irq
  );
endinterface

// File: rtl/uart_rx.sv
// UART0 receiver: 16x-oversampled 8N1 deserializer feeding a show-ahead byte FIFO.
// Optional macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 bit voting.
module uart_rx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.slave  bus
);
  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < 1) begin : g_bad_depth
      $error("uart_rx: FIFO_DEPTH must be at least 1");
    end
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx: CLK_FREQ too low for 16x oversampling at BAUD");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, state_nx;
  logic             rx_p0, rx_p1, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       sc;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_val;
  logic             shift_en, push, frame_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overrun_q, frame_err_q;
  logic             pop, full, wr_en, ovr_set;

  assign rx_s = rx_p1;
  assign tick = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  // START decides at sc==9, which shifts later bits by two ticks: sc 13..15
  // of each subsequent bit are its mid-bit samples 7..9.
  localparam logic [3:0] START_DEC = 4'd9;
  localparam logic [3:0] BIT_DEC   = 4'd15;

  logic       vote_a, vote_b;
  logic [3:0] vote_first;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign vote_first = (state == START) ? 4'd7 : 4'd13;

  always_ff @(posedge clk) begin
    if (tick && sc == vote_first)         vote_a <= rx_s;
    if (tick && sc == vote_first + 4'd1)  vote_b <= rx_s;
  end

  assign bit_val = maj3(vote_a, vote_b, rx_s);
`else
  localparam logic [3:0] START_DEC = 4'd7;
  localparam logic [3:0] BIT_DEC   = 4'd15;

  assign bit_val = rx_s;
`endif

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: if (tick && sc == START_DEC) state_nx = bit_val ? IDLE : DATA;
      DATA:  if (tick && sc == BIT_DEC) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_nx = STOP;
             end
      STOP:  if (tick && sc == BIT_DEC) begin
               if (bit_val) begin
                 push     = 1'b1;
                 state_nx = IDLE;
               end else begin
                 frame_set = 1'b1;
                 state_nx  = BREAK;
               end
             end
      BREAK: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage: synchronizer, baud tick and frame FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      state   <= IDLE;
      div_cnt <= '0;
      sc      <= '0;
      bit_idx <= '0;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      state <= state_nx;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;
      if (state_nx != state) sc <= '0;
      else if (tick)         sc <= sc + 4'd1;
      if (state_nx != state) bit_idx <= '0;
      else if (shift_en)     bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {bit_val, shreg[7:1]};
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = bus.rd_en && (count != '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // Stage: FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovr_set)          overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
      if (frame_set)        frame_err_q <= 1'b1;
      else if (bus.clr_err) frame_err_q <= 1'b0;
    end
  end

  // Head is forced to zero when empty so reset need not touch the storage.
  assign bus.rx_data   = (count == '0) ? 8'h00 : mem[rd_ptr];
  assign bus.rx_empty  = (count == '0);
  assign bus.rx_full   = full;
  assign bus.rx_count  = count;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.irq       = (count != '0);
endmodule
